// File: rtl/miriscv_lsu_pkg.sv
// Shared types and helpers for the load/store unit: funct3 size codes, FSM state,
// byte-enable and store-data replication functions.
package miriscv_lsu_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic {
    StIdle,
    StWaitRvalid
  } lsu_state_t;

  // Enables beyond bit 3 fall off the top, so misaligned halves lose their upper byte.
  function automatic logic [3:0] lsu_be(input logic [2:0] size, input logic [1:0] offset);
    case (size)
      LSU_B, LSU_BU: return 4'b0001 << offset;
      LSU_H, LSU_HU: return 4'b0011 << offset;
      default:       return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lsu_wdata(input logic [2:0] size, input logic [31:0] data);
    case (size)
      LSU_B, LSU_BU: return {4{data[7:0]}};
      LSU_H, LSU_HU: return {2{data[15:0]}};
      default:       return data;
    endcase
  endfunction

endpackage

// File: rtl/miriscv_lsu_if.sv
// Data-port bus between the LSU (master) and the on-chip RAM (slave).
interface miriscv_lsu_if;
  logic        data_req;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_we, data_be, data_addr, data_wdata,
    input  data_gnt, data_rvalid, data_rdata
  );

  modport slave (
    input  data_req, data_we, data_be, data_addr, data_wdata,
    output data_gnt, data_rvalid, data_rdata
  );
endinterface

// File: rtl/miriscv_lsu_extend.sv
// Load-data alignment: shift the read word down by the byte offset, then
// sign- or zero-extend according to the funct3 size code.
module miriscv_lsu_extend
  import miriscv_lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  size_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  assign shifted = word_i >> {offset_i, 3'b000};

  always_comb begin
    case (size_i)
      LSU_B:   data_o = {{24{shifted[7]}}, shifted[7:0]};
      LSU_BU:  data_o = {24'b0, shifted[7:0]};
      LSU_H:   data_o = {{16{shifted[15]}}, shifted[15:0]};
      LSU_HU:  data_o = {16'b0, shifted[15:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/miriscv_lsu.sv
// Load/store unit: one core request becomes one word-aligned bus transaction.
// Optional misalignment trap enabled by defining MIRISCV_LSU_MISALIGN_EXC_EN.
module miriscv_lsu
  import miriscv_lsu_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 lsu_req_i,
  input  logic                 lsu_we_i,
  input  logic [2:0]           lsu_size_i,
  input  logic [31:0]          lsu_addr_i,
  input  logic [31:0]          lsu_data_i,
  output logic [31:0]          lsu_data_o,
  output logic                 lsu_stall_req_o,
  output logic                 lsu_misalign_o,
  miriscv_lsu_if.master        data_if
);

  lsu_state_t  state_q, state_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  offset_q, offset_d;
  logic        misalign;
  logic [31:0] ext_data;

`ifdef MIRISCV_LSU_MISALIGN_EXC_EN
  always_comb begin
    misalign = 1'b0;
    if (lsu_req_i && (state_q == StIdle)) begin
      case (lsu_size_i)
        LSU_B, LSU_BU: misalign = 1'b0;
        LSU_H, LSU_HU: misalign = lsu_addr_i[0];
        default:       misalign = |lsu_addr_i[1:0];
      endcase
    end
  end
`else
  assign misalign = 1'b0;
`endif

  assign lsu_misalign_o     = misalign;
  assign data_if.data_we    = lsu_we_i;
  assign data_if.data_addr  = {lsu_addr_i[31:2], 2'b00};
  assign data_if.data_be    = lsu_be(lsu_size_i, lsu_addr_i[1:0]);
  assign data_if.data_wdata = lsu_wdata(lsu_size_i, lsu_data_i);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= StIdle;
      size_q   <= 3'b000;
      offset_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      size_q   <= size_d;
      offset_q <= offset_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    size_d   = size_q;
    offset_d = offset_q;
    unique case (state_q)
      StIdle: begin
        if (lsu_req_i && !misalign && data_if.data_gnt) begin
          state_d  = StWaitRvalid;
          size_d   = lsu_size_i;
          offset_d = lsu_addr_i[1:0];
        end
      end
      StWaitRvalid: begin
        if (data_if.data_rvalid) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  miriscv_lsu_extend u_extend (
    .word_i   (data_if.data_rdata),
    .offset_i (offset_q),
    .size_i   (size_q),
    .data_o   (ext_data)
  );

  // Responses seen in StIdle (late or after reset) fall through untouched.
  always_comb begin
    data_if.data_req = 1'b0;
    lsu_stall_req_o  = 1'b0;
    lsu_data_o       = 32'b0;
    unique case (state_q)
      StIdle: begin
        if (lsu_req_i && !misalign) begin
          data_if.data_req = 1'b1;
          lsu_stall_req_o  = 1'b1;
        end
      end
      StWaitRvalid: begin
        lsu_stall_req_o = ~data_if.data_rvalid;
        if (data_if.data_rvalid) lsu_data_o = ext_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_miriscv_lsu.sv
// Bench for miriscv_lsu: table of accesses against a small RAM model, scoreboarded load
// data, plus gnt-stall, reset-abandon and misalignment sequences.
module tb_miriscv_lsu;
  import miriscv_lsu_pkg::*;

  typedef struct {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic        chk;
    logic [31:0] data;
  } sb_item_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lsu_req = 1'b0;
  logic        lsu_we = 1'b0;
  logic [2:0]  lsu_size = 3'b000;
  logic [31:0] lsu_addr = 32'h0;
  logic [31:0] lsu_wd = 32'h0;
  logic [31:0] lsu_rd;
  logic        stall;
  logic        misalign;
  logic        gnt_en = 1'b0;
  logic [31:0] mem [0:63];

  int total = 0;
  int bad = 0;
  sb_item_t sb[$];
  vec_t vecs[$];

  always #5 clk = ~clk;

  miriscv_lsu_if bus ();

  miriscv_lsu dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .lsu_req_i       (lsu_req),
    .lsu_we_i        (lsu_we),
    .lsu_size_i      (lsu_size),
    .lsu_addr_i      (lsu_addr),
    .lsu_data_i      (lsu_wd),
    .lsu_data_o      (lsu_rd),
    .lsu_stall_req_o (stall),
    .lsu_misalign_o  (misalign),
    .data_if         (bus.master)
  );

  assign bus.data_gnt = gnt_en;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  // RAM model: response one cycle after an accepted request; ignores LSU reset.
  always @(posedge clk) begin
    bus.data_rvalid <= bus.data_req & bus.data_gnt;
    if (bus.data_req && bus.data_gnt) begin
      bus.data_rdata <= mem[bus.data_addr[7:2]];
      if (bus.data_we)
        mem[bus.data_addr[7:2]] <= merge(mem[bus.data_addr[7:2]], bus.data_wdata, bus.data_be);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] size, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [3:0] be,
                              input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
    vec_t v;
    v.we = we; v.size = size; v.addr = addr; v.wd = wd; v.be = be;
    v.exp_wdata = exp_wdata; v.exp_rdata = exp_rdata;
    return v;
  endfunction

  // Call right after a posedge; returns right after the posedge ending the access.
  task automatic run_access(input vec_t v, input int gnt_wait, input string tag);
    int       req_no_gnt;
    int       stall_cyc;
    bit       done;
    sb_item_t it;
    req_no_gnt = 0;
    stall_cyc  = 0;
    done       = 1'b0;
    lsu_req  = 1'b1;
    lsu_we   = v.we;
    lsu_size = v.size;
    lsu_addr = v.addr;
    lsu_wd   = v.wd;
    gnt_en   = (gnt_wait == 0);
    sb.push_back('{chk: !v.we, data: v.exp_rdata});
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (c == 0) begin
        check({tag, " be"}, {28'b0, bus.data_be}, {28'b0, v.be});
        check({tag, " addr"}, bus.data_addr, {v.addr[31:2], 2'b00});
        check({tag, " we"}, {31'b0, bus.data_we}, {31'b0, v.we});
        check({tag, " idle data"}, lsu_rd, 32'h0);
        if (v.we) check({tag, " wdata"}, bus.data_wdata, v.exp_wdata);
      end
      if (bus.data_req && !bus.data_gnt) req_no_gnt++;
      if (stall) begin
        stall_cyc++;
      end else begin
        done = 1'b1;
        check({tag, " req in completion"}, {31'b0, bus.data_req}, 32'h0);
        it = sb.pop_front();
        if (it.chk) check({tag, " rdata"}, lsu_rd, it.data);
      end
      @(posedge clk);
      #1;
      if (req_no_gnt >= gnt_wait) gnt_en = 1'b1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s timeout: got no completion want completion within 20 cycles", tag);
    end
    check({tag, " stall cycles"}, stall_cyc, 1 + gnt_wait);
    check({tag, " req w/o gnt"}, req_no_gnt, gnt_wait);
    lsu_req = 1'b0;
  endtask

  initial begin
    vecs.push_back(mk(1, LSU_W,  32'h40, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 32'h0));
    vecs.push_back(mk(0, LSU_W,  32'h40, 32'h0,        4'b1111, 32'h0, 32'hDEADBEEF));
    vecs.push_back(mk(1, LSU_B,  32'h43, 32'h00000080, 4'b1000, 32'h80808080, 32'h0));
    vecs.push_back(mk(0, LSU_B,  32'h43, 32'h0,        4'b1000, 32'h0, 32'hFFFFFF80));
    vecs.push_back(mk(0, LSU_BU, 32'h43, 32'h0,        4'b1000, 32'h0, 32'h00000080));
    vecs.push_back(mk(1, LSU_H,  32'h42, 32'h12348001, 4'b1100, 32'h80018001, 32'h0));
    vecs.push_back(mk(0, LSU_H,  32'h42, 32'h0,        4'b1100, 32'h0, 32'hFFFF8001));
    vecs.push_back(mk(0, LSU_HU, 32'h42, 32'h0,        4'b1100, 32'h0, 32'h00008001));
    vecs.push_back(mk(0, LSU_B,  32'h40, 32'h0,        4'b0001, 32'h0, 32'hFFFFFFEF));
    vecs.push_back(mk(0, LSU_BU, 32'h41, 32'h0,        4'b0010, 32'h0, 32'h000000BE));
    vecs.push_back(mk(0, LSU_H,  32'h40, 32'h0,        4'b0011, 32'h0, 32'hFFFFBEEF));
    vecs.push_back(mk(0, 3'b111, 32'h40, 32'h0,        4'b1111, 32'h0, 32'h8001BEEF));
    vecs.push_back(mk(1, LSU_B,  32'h41, 32'hFFFFFF5A, 4'b0010, 32'h5A5A5A5A, 32'h0));
    vecs.push_back(mk(0, 3'b011, 32'h40, 32'h0,        4'b1111, 32'h0, 32'h80015AEF));
`ifndef MIRISCV_LSU_MISALIGN_EXC_EN
    vecs.push_back(mk(0, LSU_HU, 32'h43, 32'h0,        4'b1000, 32'h0, 32'h00000080));
    vecs.push_back(mk(0, LSU_W,  32'h41, 32'h0,        4'b1111, 32'h0, 32'h0080015A));
`endif

    repeat (3) @(posedge clk);
    #1;
    check("reset stall", {31'b0, stall}, 32'h0);
    check("reset req", {31'b0, bus.data_req}, 32'h0);
    check("reset misalign", {31'b0, misalign}, 32'h0);
    check("reset data", lsu_rd, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) run_access(vecs[i], 0, $sformatf("vec%0d", i));

    // Grant withheld for three request cycles.
    run_access(mk(0, LSU_W, 32'h40, 32'h0, 4'b1111, 32'h0, 32'h80015AEF), 3, "gnt_wait");

    // Reset while waiting for rvalid: the response that follows must be dropped.
    lsu_req  = 1'b1;
    lsu_we   = 1'b0;
    lsu_size = LSU_W;
    lsu_addr = 32'h40;
    gnt_en   = 1'b1;
    @(negedge clk);
    check("rst seq stall before", {31'b0, stall}, 32'h1);
    @(posedge clk);
    #1;
    lsu_req = 1'b0;
    rst_n   = 1'b0;
    #1;
    check("rst seq stall", {31'b0, stall}, 32'h0);
    check("rst seq req", {31'b0, bus.data_req}, 32'h0);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("late rvalid data", lsu_rd, 32'h0);
    check("late rvalid stall", {31'b0, stall}, 32'h0);
    @(posedge clk);
    #1;
    run_access(mk(0, LSU_HU, 32'h42, 32'h0, 4'b1100, 32'h0, 32'h00008001), 0, "post_rst");

`ifdef MIRISCV_LSU_MISALIGN_EXC_EN
    lsu_req  = 1'b1;
    lsu_we   = 1'b0;
    lsu_size = LSU_W;
    lsu_addr = 32'h41;
    gnt_en   = 1'b1;
    @(negedge clk);
    check("mis flag", {31'b0, misalign}, 32'h1);
    check("mis req", {31'b0, bus.data_req}, 32'h0);
    check("mis stall", {31'b0, stall}, 32'h0);
    @(posedge clk);
    #1;
    lsu_req = 1'b0;
    @(negedge clk);
    check("mis clear", {31'b0, misalign}, 32'h0);
    check("mis no rvalid data", lsu_rd, 32'h0);
    @(posedge clk);
    #1;
`else
    lsu_req  = 1'b1;
    lsu_size = LSU_W;
    lsu_addr = 32'h41;
    @(negedge clk);
    check("mis tied low", {31'b0, misalign}, 32'h0);
    @(posedge clk);
    #1;
    lsu_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
